// File: rtl/i2c_reg_seq.sv
// i2c_reg_seq: drives the I2C master's IO register port to run one complete
// single-byte register write or register read per request, polling the
// master's status register for completion and reporting a status code.
module i2c_reg_seq #(
  parameter logic [5:0]  master_base = 6'h19,
  parameter logic [15:0] prescale    = 16'd99,
  parameter logic [15:0] poll_limit  = 16'd50000
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       req,
  input  logic       req_rd,
  input  logic [6:0] req_dev,
  input  logic [7:0] req_reg,
  input  logic [7:0] req_wdata,
  output logic       busy,
  output logic       done,
  output logic [1:0] err_code,
  output logic [7:0] rdata,
  output logic [5:0] m_io_a,
  output logic [7:0] m_io_do,
  input  logic [7:0] m_io_di,
  output logic       m_io_re,
  output logic       m_io_we
);

  // Master register map relative to master_base
  localparam logic [5:0] A_PRERLO = master_base + 6'd0;
  localparam logic [5:0] A_PRERHI = master_base + 6'd1;
  localparam logic [5:0] A_CTR    = master_base + 6'd2;
  localparam logic [5:0] A_TXR    = master_base + 6'd3;
  localparam logic [5:0] A_RXR    = master_base + 6'd4;
  localparam logic [5:0] A_CR     = master_base + 6'd5;
  localparam logic [5:0] A_SR     = master_base + 6'd6;

  // Master command bytes
  localparam logic [7:0] CMD_STA_WR = 8'h90;
  localparam logic [7:0] CMD_WR     = 8'h10;
  localparam logic [7:0] CMD_STO_WR = 8'h50;
  localparam logic [7:0] CMD_STO_RD = 8'h68;
  localparam logic [7:0] CMD_STO    = 8'h40;
  localparam logic [7:0] CMD_IACK   = 8'h01;

  localparam logic [3:0] ST_INIT0     = 4'd0;
  localparam logic [3:0] ST_INIT1     = 4'd1;
  localparam logic [3:0] ST_INIT2     = 4'd2;
  localparam logic [3:0] ST_INIT3     = 4'd3;
  localparam logic [3:0] ST_IDLE      = 4'd4;
  localparam logic [3:0] ST_TXR       = 4'd5;
  localparam logic [3:0] ST_CMD       = 4'd6;
  localparam logic [3:0] ST_POLL_RD   = 4'd7;
  localparam logic [3:0] ST_POLL_WAIT = 4'd8;
  localparam logic [3:0] ST_POLL_CHK  = 4'd9;
  localparam logic [3:0] ST_EVAL      = 4'd10;
  localparam logic [3:0] ST_RXR_WAIT  = 4'd11;
  localparam logic [3:0] ST_RXR_CAP   = 4'd12;

  logic [3:0]  state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [15:0] poll_cnt_q, poll_cnt_d;
  logic        rd_q, rd_d;
  logic [6:0]  dev_q, dev_d;
  logic [7:0]  reg_q, reg_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        al_q, al_d;
  logic        rxack_q, rxack_d;
  logic        sto_q, sto_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [1:0]  err_q, err_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [5:0]  a_q, a_d;
  logic [7:0]  do_q, do_d;
  logic        re_q, re_d;
  logic        we_q, we_d;

  logic        data_step;
  logic        last_step;
  logic [7:0]  step_txr;
  logic [7:0]  step_cmd;

  assign busy     = busy_q;
  assign done     = done_q;
  assign err_code = err_q;
  assign rdata    = rdata_q;
  assign m_io_a   = a_q;
  assign m_io_do  = do_q;
  assign m_io_re  = re_q;
  assign m_io_we  = we_q;

  // The read-data step of a read has no TXR byte and is the only non-WR step
  assign data_step = rd_q && (step_q == 2'd3);
  assign last_step = rd_q ? (step_q == 2'd3) : (step_q == 2'd2);

  // TXR byte and CR command for the current step
  always_comb begin
    step_txr = 8'h00;
    step_cmd = CMD_STA_WR;
    case (step_q)
      2'd0: begin
        step_txr = {dev_q, 1'b0};
        step_cmd = CMD_STA_WR;
      end
      2'd1: begin
        step_txr = reg_q;
        step_cmd = CMD_WR;
      end
      2'd2: begin
        step_txr = rd_q ? {dev_q, 1'b1} : wdata_q;
        step_cmd = rd_q ? CMD_STA_WR : CMD_STO_WR;
      end
      default: begin
        step_txr = 8'h00;
        step_cmd = CMD_STO_RD;
      end
    endcase
  end

  // State register and registered outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_INIT0;
      step_q     <= 2'd0;
      poll_cnt_q <= 16'd0;
      rd_q       <= 1'b0;
      dev_q      <= 7'd0;
      reg_q      <= 8'd0;
      wdata_q    <= 8'd0;
      al_q       <= 1'b0;
      rxack_q    <= 1'b0;
      sto_q      <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 2'd0;
      rdata_q    <= 8'd0;
      a_q        <= 6'd0;
      do_q       <= 8'd0;
      re_q       <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      poll_cnt_q <= poll_cnt_d;
      rd_q       <= rd_d;
      dev_q      <= dev_d;
      reg_q      <= reg_d;
      wdata_q    <= wdata_d;
      al_q       <= al_d;
      rxack_q    <= rxack_d;
      sto_q      <= sto_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
      a_q        <= a_d;
      do_q       <= do_d;
      re_q       <= re_d;
      we_q       <= we_d;
    end
  end

  // Next-state and next-output logic; at most one IO strobe is requested per cycle
  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    poll_cnt_d = poll_cnt_q;
    rd_d       = rd_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    al_d       = al_q;
    rxack_d    = rxack_q;
    sto_d      = sto_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    rdata_d    = rdata_q;
    a_d        = a_q;
    do_d       = do_q;
    re_d       = 1'b0;
    we_d       = 1'b0;

    case (state_q)
      ST_INIT0: begin
        we_d    = 1'b1;
        a_d     = A_CTR;
        do_d    = 8'h00;
        state_d = ST_INIT1;
      end
      ST_INIT1: begin
        we_d    = 1'b1;
        a_d     = A_PRERLO;
        do_d    = prescale[7:0];
        state_d = ST_INIT2;
      end
      ST_INIT2: begin
        we_d    = 1'b1;
        a_d     = A_PRERHI;
        do_d    = prescale[15:8];
        state_d = ST_INIT3;
      end
      ST_INIT3: begin
        we_d    = 1'b1;
        a_d     = A_CTR;
        do_d    = 8'h80;
        state_d = ST_IDLE;
      end
      ST_IDLE: begin
        busy_d = 1'b0;
        // busy_q guards the first IDLE cycle after INIT, when busy is still high
        if (req && !busy_q) begin
          rd_d    = req_rd;
          dev_d   = req_dev;
          reg_d   = req_reg;
          wdata_d = req_wdata;
          busy_d  = 1'b1;
          err_d   = 2'd0;
          step_d  = 2'd0;
          sto_d   = 1'b0;
          state_d = ST_TXR;
        end
      end
      ST_TXR: begin
        we_d = 1'b1;
        if (data_step) begin
          a_d        = A_CR;
          do_d       = step_cmd;
          poll_cnt_d = 16'd0;
          state_d    = ST_POLL_RD;
        end else begin
          a_d     = A_TXR;
          do_d    = step_txr;
          state_d = ST_CMD;
        end
      end
      ST_CMD: begin
        we_d       = 1'b1;
        a_d        = A_CR;
        do_d       = step_cmd;
        poll_cnt_d = 16'd0;
        state_d    = ST_POLL_RD;
      end
      ST_POLL_RD: begin
        re_d       = 1'b1;
        a_d        = A_SR;
        poll_cnt_d = poll_cnt_q + 16'd1;
        state_d    = ST_POLL_WAIT;
      end
      ST_POLL_WAIT: begin
        state_d = ST_POLL_CHK;
      end
      ST_POLL_CHK: begin
        if (m_io_di[0]) begin
          we_d    = 1'b1;
          a_d     = A_CR;
          do_d    = CMD_IACK;
          al_d    = m_io_di[5];
          rxack_d = m_io_di[7];
          state_d = ST_EVAL;
        end else if (poll_cnt_q >= poll_limit) begin
          // Timeout: report now, keep busy through the re-init
          done_d  = 1'b1;
          err_d   = 2'd3;
          sto_d   = 1'b0;
          state_d = ST_INIT0;
        end else begin
          state_d = ST_POLL_RD;
        end
      end
      ST_EVAL: begin
        if (sto_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = 2'd1;
          sto_d   = 1'b0;
          state_d = ST_IDLE;
        end else if (al_q) begin
          // Master already released the bus; no STOP
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = 2'd2;
          state_d = ST_IDLE;
        end else if (!data_step && rxack_q) begin
          err_d      = 2'd1;
          we_d       = 1'b1;
          a_d        = A_CR;
          do_d       = CMD_STO;
          poll_cnt_d = 16'd0;
          sto_d      = 1'b1;
          state_d    = ST_POLL_RD;
        end else if (last_step && !rd_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          err_d   = 2'd0;
          state_d = ST_IDLE;
        end else if (last_step) begin
          re_d    = 1'b1;
          a_d     = A_RXR;
          state_d = ST_RXR_WAIT;
        end else begin
          step_d  = step_q + 2'd1;
          state_d = ST_TXR;
        end
      end
      ST_RXR_WAIT: begin
        state_d = ST_RXR_CAP;
      end
      ST_RXR_CAP: begin
        rdata_d = m_io_di;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        err_d   = 2'd0;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_INIT0;
      end
    endcase
  end

endmodule
